// File: rtl/io_pkg.sv
// Shared constants for the Hack CPU I/O window: register offsets, window size, default base.
package io_pkg;

    localparam int          IO_WIN          = 5;
    localparam logic [14:0] IO_BASE_DEFAULT = 15'h6001;

    localparam logic [2:0] IO_OFS_LED  = 3'd0;
    localparam logic [2:0] IO_OFS_DIR  = 3'd1;
    localparam logic [2:0] IO_OFS_OUT  = 3'd2;
    localparam logic [2:0] IO_OFS_IN   = 3'd3;
    localparam logic [2:0] IO_OFS_EDGE = 3'd4;

    typedef struct packed {
        logic led;
        logic dir;
        logic out;
    } ioStrobe_t;

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus run-length debouncer for the raw GPIO pin.
// The pulses are combinational and mark the edge on which stable flips.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic gpioRaw,
    output logic stable,
    output logic rosePulse,
    output logic fellPulse
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1;
    logic        syncIn;
    logic [15:0] cnt;
    logic        accept;

    assign accept    = (syncIn != stable) && (cnt == CNT_LAST);
    assign rosePulse = accept & syncIn;
    assign fellPulse = accept & ~syncIn;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 1'b0;
            syncIn <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= gpioRaw;
            syncIn <= sync1;
            // cnt never passes CNT_LAST: it clears on accept or on agreement
            if (syncIn == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= syncIn;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/io_mmio_bridge.sv
// Decodes CPU writes into registered ioports load strobes, debounces the GPIO
// input with sticky edge flags, and serves everything back on the read path.
module io_mmio_bridge
    import io_pkg::*;
#(
    parameter logic [14:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic        ioSel,
    output logic [15:0] ioData,
    output logic        dataIn,
    output logic        ledLoad,
    output logic        gpioDir,
    output logic        gpioLoad,
    input  logic        gpioRaw,
    output logic        gpioEdge
);

    logic [14:0] ofs;
    logic [2:0]  ofs3;
    logic        wrHit;
    logic        wrEdge;
    ioStrobe_t   wr;
    logic        ledShadow, dirShadow, outShadow;
    logic        rise, fall;
    logic        stable, rosePulse, fellPulse;
    logic        unusedBits;

    // Addresses below IO_BASE wrap to large offsets, so one compare covers both bounds
    assign ofs    = addressM - IO_BASE;
    assign ofs3   = ofs[2:0];
    assign ioSel  = RST_N && (ofs < 15'(IO_WIN));
    assign wrHit  = writeM && ioSel;
    assign wr.led = wrHit && (ofs3 == IO_OFS_LED);
    assign wr.dir = wrHit && (ofs3 == IO_OFS_DIR);
    assign wr.out = wrHit && (ofs3 == IO_OFS_OUT);
    assign wrEdge = wrHit && (ofs3 == IO_OFS_EDGE);

    assign gpioEdge   = rise | fall;
    assign unusedBits = ^outM[15:2];

    gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .gpioRaw  (gpioRaw),
        .stable   (stable),
        .rosePulse(rosePulse),
        .fellPulse(fellPulse)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ledLoad   <= 1'b0;
            gpioDir   <= 1'b0;
            gpioLoad  <= 1'b0;
            dataIn    <= 1'b0;
            ledShadow <= 1'b0;
            dirShadow <= 1'b0;
            outShadow <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            ledLoad  <= wr.led;
            gpioDir  <= wr.dir;
            gpioLoad <= wr.out;
            if (wr.led) ledShadow <= outM[0];
            if (wr.dir) dirShadow <= outM[0];
            if (wr.out) outShadow <= outM[0];
            if (|wr)    dataIn    <= outM[0];
            // A new edge outranks a same-cycle write-1-to-clear
            rise <= rosePulse | (rise & ~(wrEdge & outM[0]));
            fall <= fellPulse | (fall & ~(wrEdge & outM[1]));
        end
    end

    always_comb begin
        ioData = '0;
        if (ioSel) begin
            case (ofs3)
                IO_OFS_LED:  ioData = {15'b0, ledShadow};
                IO_OFS_DIR:  ioData = {15'b0, dirShadow};
                IO_OFS_OUT:  ioData = {15'b0, outShadow};
                IO_OFS_IN:   ioData = {15'b0, stable};
                IO_OFS_EDGE: ioData = {14'b0, fall, rise};
                default:     ioData = '0;
            endcase
        end
    end

endmodule
